// File: rtl/dither_pkg.sv
// Shared types and constants for the dither pixel sequencer.
// Holds the FSM state encoding, nb_en bit positions and default image size.
package dither_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NB_FWD   = 3;
  localparam int NB_DBACK = 2;
  localparam int NB_DOWN  = 1;
  localparam int NB_DFWD  = 0;

  localparam int DEF_IMAGEX = 256;
  localparam int DEF_IMAGEY = 256;

endpackage

// File: rtl/dither_sequencer_if.sv
// Control and pixel-coordinate bundle between the sequencer (master) and the
// error-diffusion datapath (slave).
interface dither_sequencer_if #(
  parameter int IMAGEX = 256,
  parameter int IMAGEY = 256,
  parameter int ADDR_W = $clog2(IMAGEX * IMAGEY)
);
  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  logic              start;
  logic              abort;
  logic              px_ready;
  logic              px_valid;
  logic [ADDR_W-1:0] px_addr;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic [3:0]        nb_en;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, px_ready,
    output px_valid, px_addr, px_x, px_y, nb_en, busy, done
  );

  modport slave (
    output start, abort, px_ready,
    input  px_valid, px_addr, px_x, px_y, nb_en, busy, done
  );

endinterface

// File: rtl/dither_coord_cnt.sv
// x/y/raster-address counters; i_dir=1 scans the current row with x descending.
// With DITHER_SERPENTINE_EN the row end keeps x so the next row reverses from there.
module dither_coord_cnt #(
  parameter int IMAGEX = 4,
  parameter int IMAGEY = 4,
  parameter int ADDR_W = 4,
  parameter int XW     = 2,
  parameter int YW     = 2
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic              i_dir,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_row_end,
  output logic              o_last_pixel
);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;

  assign o_row_end    = i_dir ? (r_x == '0) : (r_x == XW'(IMAGEX - 1));
  assign o_last_pixel = o_row_end && (r_y == YW'(IMAGEY - 1));
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_addr       = r_addr;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_adv) begin
      if (o_row_end) begin
        r_y <= r_y + YW'(1);
`ifdef DITHER_SERPENTINE_EN
        // x stays put: the pixel directly below is where the next row starts
        r_addr <= r_addr + ADDR_W'(IMAGEX);
`else
        r_x    <= '0;
        r_addr <= r_addr + ADDR_W'(1);
`endif
      end else if (i_dir) begin
        r_x    <= r_x - XW'(1);
        r_addr <= r_addr - ADDR_W'(1);
      end else begin
        r_x    <= r_x + XW'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/dither_sequencer.sv
// Walks an IMAGEX x IMAGEY image one pixel per accepted handshake, flagging valid
// error-diffusion neighbours. DITHER_SERPENTINE_EN selects boustrophedon order.
module dither_sequencer
  import dither_pkg::*;
#(
  parameter int IMAGEX = DEF_IMAGEX,
  parameter int IMAGEY = DEF_IMAGEY,
  parameter int ADDR_W = $clog2(IMAGEX * IMAGEY)
) (
  input logic                 clk,
  input logic                 rst,
  dither_sequencer_if.master  bus
);

  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  state_t            r_state;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_clr;
  logic              w_adv;
  logic              w_dir;
  logic              w_row_end;
  logic              w_last;
  logic              w_first_col;
  logic              w_last_row;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_nb;

  assign w_accept = (r_state == ST_RUN) && bus.px_ready && !bus.abort;
  assign w_adv    = w_accept && !w_last;
  // Counters return to the origin on reset, abort, start and frame completion
  assign w_clr    = rst || bus.abort || ((r_state == ST_IDLE) && bus.start)
                    || (w_accept && w_last);

`ifdef DITHER_SERPENTINE_EN
  logic r_dir;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_dir <= 1'b0;
    end else if (w_adv && w_row_end) begin
      r_dir <= ~r_dir;
    end
  end

  assign w_dir = r_dir;
`else
  assign w_dir = 1'b0;
`endif

  dither_coord_cnt #(
    .IMAGEX (IMAGEX),
    .IMAGEY (IMAGEY),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_cnt (
    .clk          (clk),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .i_dir        (w_dir),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_addr       (w_addr),
    .o_row_end    (w_row_end),
    .o_last_pixel (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_accept && w_last) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Borders are in scan terms: "first column" is where the current row began
  assign w_first_col = w_dir ? (w_x == XW'(IMAGEX - 1)) : (w_x == '0);
  assign w_last_row  = (w_y == YW'(IMAGEY - 1));

  always_comb begin
    w_nb = '0;
    if (r_valid) begin
      w_nb[NB_FWD]   = !w_row_end;
      w_nb[NB_DBACK] = !w_first_col && !w_last_row;
      w_nb[NB_DOWN]  = !w_last_row;
      w_nb[NB_DFWD]  = !w_row_end && !w_last_row;
    end
  end

  assign bus.px_valid = r_valid;
  assign bus.px_addr  = w_addr;
  assign bus.px_x     = w_x;
  assign bus.px_y     = w_y;
  assign bus.nb_en    = w_nb;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
